cardinal_nic_q: RTL and testbench
=================================

CARDINAL_NIC_Q -- requirements
Module: cardinal_nic_q

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 64: width of the processor and network words.
REQ-002 SHALL take parameter IN_DEPTH, default 4: input-queue entries; power of two, at least 2.
REQ-003 SHALL take parameter OUT_DEPTH, default 4: output-queue entries; power of two, at least 2.
REQ-004 Ports, in this order:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  register select: 00 input data, 01 input status, 10 output data, 11 output status.
- d_in  in  DATA_WIDTH  processor store data.
- d_out  out  DATA_WIDTH  processor load data, registered.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1 = store, 0 = load.
- net_si  in  1  router send-in request.
- net_ri  out  1  NIC ready to accept from the router.
- net_di  in  DATA_WIDTH  router data in.
- net_so  out  1  NIC send-out valid.
- net_ro  in  1  router ready to accept from the NIC.
- net_polarity  in  1  router's current cycle polarity.
- net_do  out  DATA_WIDTH  head of the output queue.
- irq  out  1  present only with CARDINAL_NIC_IRQ_EN.
REQ-005 Bit ordering SHALL be [0:DATA_WIDTH-1]; bit 0 is the packet virtual-channel (polarity) bit.

Function
REQ-006 Input queue:
- net_ri = input queue not full.
- When net_si=1 and net_ri=1, net_di SHALL be pushed at the clock edge.
REQ-007 Load from 00 when the input queue is non-empty: d_out <= head next edge, and the head is popped on the same edge.
REQ-008 Load from 00 when the input queue is empty: d_out holds and no pop occurs; there is no bypass from net_di.
REQ-009 Simultaneous push and pop on the input queue SHALL both take effect. When full, net_ri=0, so a pop that cycle frees the slot for the next cycle.
REQ-010 Output queue:
- net_do = output-queue head, combinational.
- net_so = net_ro & (output queue non-empty) & (net_polarity != head bit 0), combinational.
- When net_so=1, the head SHALL be popped at the edge.
REQ-011 Store to 10 when the output queue is not full SHALL push d_in. Store to 10 when full SHALL be dropped with no state change. Simultaneous push and pop SHALL both take effect.
REQ-012 Load from 10 SHALL return the output-queue head; garbage-free: zero when empty. The load does not pop.
REQ-013 Status loads:
- 01: bit DATA_WIDTH-1 = input non-empty.
- 11: bit DATA_WIDTH-1 = output full.
- In both, the occupancy count (width clog2(DEPTH)+1, LSB at bit DATA_WIDTH-2) sits in the bits immediately above the flag; all other bits are 0.
REQ-014 d_out SHALL hold its value on cycles without a load. Stores to 00, 01 or 11 SHALL be ignored, except as in REQ-020.
REQ-015 Queue pointers SHALL wrap modulo depth. Occupancy SHALL be tracked with a count one bit wider than the pointer, so full and empty are unambiguous.

Reset
REQ-016 While reset=0, asynchronously:
- both queues empty, pointers and counts 0;
- d_out = 0, net_ri = 1, net_so = 0;
- irq = 0, irq mask = 0.
REQ-017 Reset asserted mid-transfer SHALL discard all queued words. The first edge after deassertion SHALL behave as from the empty state.

Configuration
REQ-018 Macro CARDINAL_NIC_IRQ_EN.
REQ-019 When CARDINAL_NIC_IRQ_EN is defined, the design SHALL include a 1-bit irq mask register and a registered irq output.
REQ-020 With the macro defined, a store to 01 SHALL write the mask from d_in bit DATA_WIDTH-1.
REQ-021 With the macro defined, irq SHALL be registered: irq <= mask & (input queue non-empty after the edge's updates).
REQ-022 With the macro undefined, the irq port and mask SHALL be absent, and stores to 01 SHALL be ignored.

Structure
REQ-023 Package cardinal_nic_pkg SHALL hold the address constants (ADDR_IN_DATA, ADDR_IN_STAT, ADDR_OUT_DATA, ADDR_OUT_STAT) and the status-word field positions.
REQ-024 Both queues SHALL be instances of one sub-module, nic_fifo (parameters WIDTH, DEPTH), with:
- push and pop interfaces;
- head, full, empty and count outputs;
- asynchronous active-low reset.

Verification
REQ-025 Router pushes words 1..5 with IN_DEPTH=4 -> net_ri falls after the 4th push; word 5 is held off; a load from 00 returns 1, and net_ri rises the next cycle.
REQ-026 A load from 00 while the input queue is empty -> d_out unchanged and count stays 0. Then net_si with net_di=0xA5 and a load from 00 in the same cycle -> d_out unchanged and count becomes 1.
REQ-027 Store 0x8000_0000_0000_0001 (bit0=1) with net_polarity=1 and net_ro=1 -> net_so=0. When polarity toggles to 0 -> net_so=1 for one cycle, the word pops, and the 11 status reads 0.
REQ-028 Five stores to 10 with OUT_DEPTH=4 and net_ro=0 -> the fifth is dropped; the 11 status shows full=1 and count=4; stores 1..4 drain in order.
REQ-029 Reset pulsed low with both queues half-full -> immediately d_out=0, net_so=0, net_ri=1; all status counts read 0.
REQ-030 With CARDINAL_NIC_IRQ_EN defined: store mask=1, then a router push -> irq=1 one edge after the push. A load from 00 emptying the queue -> irq=0 on the following edge.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg
// Shared constants for the cardinal NIC: the processor-side register map and
// the layout of the two status words.
//
// Data words use [0:DATA_WIDTH-1] ordering. Bit 0 is the leftmost, most
// significant bit and carries the packet virtual-channel (polarity) bit.
// Bit DATA_WIDTH-1 is the rightmost, least significant bit.
//
// Status word layout, with offsets counted from bit DATA_WIDTH-1:
//   offset 0              flag (input non-empty / output full)
//   offsets 1..CW         occupancy count, LSB at bit DATA_WIDTH-2
//   all other bits        zero
package cardinal_nic_pkg;

  // Processor register select.
  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  // Status field offsets from the least significant end (bit DATA_WIDTH-1).
  localparam int STAT_FLAG_OFS  = 0;
  localparam int STAT_COUNT_OFS = 1;

endpackage

// File: rtl/cardinal_nic_q_fifo.sv
// nic_fifo
// Circular-buffer FIFO used for both NIC queues.
//
// Parameters:
//   WIDTH  word width
//   DEPTH  number of entries; must be a power of two, at least 2
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; empties the queue
//   push       write push_data at the edge (ignored when full)
//   push_data  word to enqueue
//   pop        drop the head at the edge (ignored when empty)
//   head       current head word, combinational (stale when empty)
//   full       count == DEPTH
//   empty      count == 0
//   count      occupancy, one bit wider than the pointers
//
// A simultaneous push and pop both take effect and leave count unchanged.
module nic_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [0:WIDTH-1]       push_data,
  input  logic                   pop,
  output logic [0:WIDTH-1]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [0:WIDTH-1] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Guard the requests internally so callers cannot overflow or underflow.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two. The extra count
  // bit keeps full and empty distinct when the pointers are equal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cardinal_nic_q.sv
// cardinal_nic_q
// Network interface between a processor register port and a router link.
// It holds an input queue (router -> processor) and an output queue
// (processor -> router).
//
// Optional feature macro: CARDINAL_NIC_IRQ_EN adds an irq mask register,
// written by a store to the input-status address, and a registered irq output.
//
// Parameters:
//   DATA_WIDTH  processor and network word width
//   IN_DEPTH    input-queue entries (power of two, >= 2)
//   OUT_DEPTH   output-queue entries (power of two, >= 2)
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   addr              00 in data, 01 in status, 10 out data, 11 out status
//   d_in, d_out       processor store data / registered load data
//   nicEn, nicWrEn    access enable; 1 = store, 0 = load
//   net_si, net_ri    router -> NIC request / NIC ready
//   net_di            router -> NIC data
//   net_so, net_ro    NIC -> router valid / router ready
//   net_polarity      router's current cycle polarity
//   net_do            output-queue head
//   irq               (CARDINAL_NIC_IRQ_EN only) registered interrupt
//
// Router handshake: a word moves across a link at the rising edge where both
// sides agree in that cycle. On the input link this means net_si & net_ri. On
// the output link, net_so already includes net_ro and the polarity match, so
// net_so alone marks the transfer. Neither side may depend on a transfer that
// has not yet happened at an edge.
module cardinal_nic_q
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  input  logic                  net_polarity,
  output logic [0:DATA_WIDTH-1] net_do
`ifdef CARDINAL_NIC_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  // Index of the least significant bit and base of the count field in the
  // ascending [0:DATA_WIDTH-1] numbering.
  localparam int FLAG_BIT      = DATA_WIDTH - 1 - STAT_FLAG_OFS;
  localparam int IN_CNT_BASE   = DATA_WIDTH - STAT_COUNT_OFS - IN_CW;
  localparam int OUT_CNT_BASE  = DATA_WIDTH - STAT_COUNT_OFS - OUT_CW;

  logic                  is_load;
  logic                  is_store;

  logic                  in_push;
  logic                  in_pop;
  logic [0:DATA_WIDTH-1] in_head;
  logic                  in_full;
  logic                  in_empty;
  logic [IN_CW-1:0]      in_count;

  logic                  out_push;
  logic                  out_pop;
  logic [0:DATA_WIDTH-1] out_head;
  logic                  out_full;
  logic                  out_empty;
  logic [OUT_CW-1:0]     out_count;

  logic [0:DATA_WIDTH-1] in_stat;
  logic [0:DATA_WIDTH-1] out_stat;

  assign is_load  = nicEn & ~nicWrEn;
  assign is_store = nicEn & nicWrEn;

  // Input queue: the router pushes whenever a slot is free. A processor load
  // pops only when there is something to return; there is no bypass path
  // from net_di, so a load on an empty queue just holds d_out.
  assign net_ri  = ~in_full;
  assign in_push = net_si & net_ri;
  assign in_pop  = is_load & (addr == ADDR_IN_DATA) & ~in_empty;

  nic_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (IN_DEPTH)
  ) u_in_q (
    .clk       (clk),
    .reset     (reset),
    .push      (in_push),
    .push_data (net_di),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  // Output queue: a word leaves only in a cycle whose polarity differs from
  // its virtual-channel bit (bit 0). A store to a full queue is dropped
  // inside the FIFO, even if a pop frees a slot at the same edge.
  assign out_push = is_store & (addr == ADDR_OUT_DATA);
  assign net_so   = net_ro & ~out_empty & (net_polarity != out_head[0]);
  assign out_pop  = net_so;
  assign net_do   = out_head;

  nic_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_q (
    .clk       (clk),
    .reset     (reset),
    .push      (out_push),
    .push_data (d_in),
    .pop       (out_pop),
    .head      (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  // Status words: the flag sits in the least significant bit. The occupancy
  // count sits directly above it, with its LSB at bit DATA_WIDTH-2.
  always_comb begin
    in_stat                           = '0;
    in_stat[FLAG_BIT]                 = ~in_empty;
    in_stat[IN_CNT_BASE +: IN_CW]     = in_count;
  end

  always_comb begin
    out_stat                          = '0;
    out_stat[FLAG_BIT]                = out_full;
    out_stat[OUT_CNT_BASE +: OUT_CW]  = out_count;
  end

  // Load data register. It holds on every cycle without a load, and also on
  // a load of an empty input queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (is_load) begin
      case (addr)
        ADDR_IN_DATA:  if (!in_empty) d_out <= in_head;
        ADDR_IN_STAT:  d_out <= in_stat;
        ADDR_OUT_DATA: d_out <= out_empty ? '0 : out_head;
        ADDR_OUT_STAT: d_out <= out_stat;
        default:       d_out <= d_out;
      endcase
    end
  end

`ifdef CARDINAL_NIC_IRQ_EN
  logic irq_mask;
  logic in_nonempty_next;

  // The input queue is non-empty after this edge if a word arrives, or if
  // at least one word survives a possible pop.
  assign in_nonempty_next = in_push
                          | (in_count > IN_CW'(1))
                          | (~in_empty & ~in_pop);

  // irq uses the mask value held before this edge. A mask write takes
  // effect on irq from the following edge onward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (is_store && (addr == ADDR_IN_STAT)) irq_mask <= d_in[DATA_WIDTH-1];
      irq <= irq_mask & in_nonempty_next;
    end
  end
`endif

endmodule

// File: tb/tb_cardinal_nic_q.sv
module tb_cardinal_nic_q;

  localparam int DW = 64;
  localparam int ID = 4;
  localparam int OD = 4;

  // Bench words are declared [DW-1:0]. They connect to the DUT's [0:DW-1]
  // ports position by position, so DUT bit 0 (polarity) is bench bit DW-1,
  // and DUT bit DW-1 (mask / status flag) is bench bit 0.
  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          nicEn;
  logic          nicWrEn;
  logic          net_si;
  logic          net_ri;
  logic [DW-1:0] net_di;
  logic          net_so;
  logic          net_ro;
  logic          net_polarity;
  logic [DW-1:0] net_do;
`ifdef CARDINAL_NIC_IRQ_EN
  logic          irq;
`endif

  // Reference model state.
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] m_dout;
  logic          m_mask;
  logic          m_irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cardinal_nic_q #(
    .DATA_WIDTH (DW),
    .IN_DEPTH   (ID),
    .OUT_DEPTH  (OD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_polarity (net_polarity),
    .net_do       (net_do)
`ifdef CARDINAL_NIC_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  function automatic logic m_ri();
    return in_q.size() < ID;
  endfunction

  function automatic logic m_so();
    return net_ro && (out_q.size() != 0) && (net_polarity != out_q[0][DW-1]);
  endfunction

  function automatic logic [DW-1:0] stat_word(input int cnt, input logic flag);
    return (DW'(cnt) << 1) | DW'(flag);
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0;
    net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
  endtask

  task automatic load(input logic [1:0] a);
    nicEn = 1; nicWrEn = 0; addr = a;
  endtask

  task automatic store(input logic [1:0] a, input logic [DW-1:0] v);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
  endtask

  task automatic model_clear();
    in_q.delete(); out_q.delete();
    m_dout = '0; m_mask = 0; m_irq = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven, then
  // waits through the rising edge to the next falling edge.
  task automatic tick();
    logic [DW-1:0] nd;
    logic pop_in, push_in, pop_out, push_out;
    nd       = m_dout;
    pop_in   = 0;
    push_in  = net_si && m_ri();
    pop_out  = m_so();
    push_out = nicEn && nicWrEn && (addr == 2'd2) && (out_q.size() < OD);
    if (nicEn && !nicWrEn) begin
      case (addr)
        2'd0: if (in_q.size() != 0) begin nd = in_q[0]; pop_in = 1; end
        2'd1: nd = stat_word(in_q.size(), in_q.size() != 0);
        2'd2: nd = (out_q.size() != 0) ? out_q[0] : '0;
        default: nd = stat_word(out_q.size(), out_q.size() == OD);
      endcase
    end
    if (pop_in)   void'(in_q.pop_front());
    if (push_in)  in_q.push_back(net_di);
    if (pop_out)  void'(out_q.pop_front());
    if (push_out) out_q.push_back(d_in);
    m_dout = nd;
`ifdef CARDINAL_NIC_IRQ_EN
    m_irq = m_mask && (in_q.size() != 0);
    if (nicEn && nicWrEn && addr == 2'd1) m_mask = d_in[0];
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    net_ro = 1;
    reset = 0;
    model_clear();
    #3;
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL reset_d_out: got %h want 0", d_out); end
    n_cmp++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL reset_net_ri: got %b want 1", net_ri); end
    n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL reset_net_so: got %b want 0", net_so); end
`ifdef CARDINAL_NIC_IRQ_EN
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    @(negedge clk);
    reset = 1;
    load(2'd1); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL reset_in_stat: got %h want 0", d_out); end
    load(2'd3); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL reset_out_stat: got %h want 0", d_out); end
  endtask

  task automatic test_in_fill();
    idle();
    net_si = 1;
    for (int k = 1; k <= 5; k++) begin
      net_di = DW'(k);
      #1;
      n_cmp++;
      if (net_ri !== (k <= 4)) begin n_err++; $display("FAIL fill_net_ri[%0d]: got %b want %b", k, net_ri, (k <= 4)); end
      tick();
    end
    // Word 5 is still offered; the load frees a slot only for the next cycle.
    load(2'd0);
    #1;
    n_cmp++; if (net_ri !== 1'b0) begin n_err++; $display("FAIL fill_ri_before_pop: got %b want 0", net_ri); end
    tick();
    n_cmp++; if (d_out !== DW'(1)) begin n_err++; $display("FAIL fill_first_load: got %h want 1", d_out); end
    nicEn = 0;
    #1;
    n_cmp++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL fill_ri_after_pop: got %b want 1", net_ri); end
    tick();
    net_si = 0;
    for (int k = 2; k <= 5; k++) begin
      load(2'd0); tick();
      n_cmp++; if (d_out !== DW'(k)) begin n_err++; $display("FAIL fill_drain[%0d]: got %h want %h", k, d_out, DW'(k)); end
    end
  endtask

  task automatic test_in_empty();
    idle();
    load(2'd0); tick();
    n_cmp++; if (d_out !== DW'(5)) begin n_err++; $display("FAIL empty_load_hold: got %h want 5", d_out); end
    load(2'd1); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL empty_count0: got %h want 0", d_out); end
    load(2'd0); net_si = 1; net_di = DW'(8'hA5); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL empty_no_bypass: got %h want 0", d_out); end
    net_si = 0;
    load(2'd1); tick();
    n_cmp++; if (d_out !== DW'(3)) begin n_err++; $display("FAIL empty_count1: got %h want 3", d_out); end
    load(2'd0); tick();
    n_cmp++; if (d_out !== DW'(8'hA5)) begin n_err++; $display("FAIL empty_a5: got %h want a5", d_out); end
  endtask

  task automatic test_out_polarity();
    logic [DW-1:0] w;
    w = 64'h8000_0000_0000_0001;
    idle();
    net_ro = 1; net_polarity = 1;
    store(2'd2, w); tick();
    nicEn = 0;
    #1;
    n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL pol_same_blocked: got %b want 0", net_so); end
    n_cmp++; if (net_do !== w) begin n_err++; $display("FAIL pol_net_do: got %h want %h", net_do, w); end
    net_polarity = 0;
    #1;
    n_cmp++; if (net_so !== 1'b1) begin n_err++; $display("FAIL pol_diff_send: got %b want 1", net_so); end
    tick();
    #1;
    n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL pol_after_pop: got %b want 0", net_so); end
    // Stores to non-data addresses leave both queues untouched.
    store(2'd0, rnd_word()); tick();
    store(2'd3, rnd_word()); tick();
    load(2'd3); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL pol_out_stat: got %h want 0", d_out); end
    load(2'd1); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL ignored_store_in_stat: got %h want 0", d_out); end
  endtask

  task automatic test_out_full();
    idle();
    for (int k = 1; k <= 5; k++) begin
      store(2'd2, 64'h1000 + DW'(k)); tick();
    end
    load(2'd3); tick();
    n_cmp++; if (d_out !== DW'(9)) begin n_err++; $display("FAIL full_stat: got %h want 9", d_out); end
    load(2'd2); tick();
    n_cmp++; if (d_out !== 64'h1001) begin n_err++; $display("FAIL full_peek: got %h want 1001", d_out); end
    nicEn = 0; net_ro = 1; net_polarity = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_cmp++; if (net_so !== 1'b1) begin n_err++; $display("FAIL drain_so[%0d]: got %b want 1", k, net_so); end
      n_cmp++; if (net_do !== 64'h1000 + DW'(k)) begin n_err++; $display("FAIL drain_do[%0d]: got %h want %h", k, net_do, 64'h1000 + DW'(k)); end
      tick();
    end
    #1;
    n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL drain_empty_so: got %b want 0", net_so); end
    load(2'd2); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL empty_out_load: got %h want 0", d_out); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] x;
    x = {32'h0000_0001, $urandom};
    idle();
    net_si = 1; net_di = rnd_word(); tick();
    net_di = rnd_word(); tick();
    net_si = 0;
    store(2'd2, x); tick();
    store(2'd2, rnd_word()); tick();
    load(2'd2); tick();
    n_cmp++; if (d_out !== x) begin n_err++; $display("FAIL mid_pre_peek: got %h want %h", d_out, x); end
    nicEn = 0; net_ro = 1; net_polarity = ~x[DW-1];
    #1;
    n_cmp++; if (net_so !== 1'b1) begin n_err++; $display("FAIL mid_pre_so: got %b want 1", net_so); end
    reset = 0;
    model_clear();
    #1;
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL mid_d_out: got %h want 0", d_out); end
    n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL mid_net_so: got %b want 0", net_so); end
    n_cmp++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL mid_net_ri: got %b want 1", net_ri); end
    @(negedge clk);
    reset = 1;
    load(2'd1); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL mid_in_stat: got %h want 0", d_out); end
    load(2'd3); tick();
    n_cmp++; if (d_out !== '0) begin n_err++; $display("FAIL mid_out_stat: got %h want 0", d_out); end
  endtask

`ifdef CARDINAL_NIC_IRQ_EN
  task automatic test_irq();
    idle();
    store(2'd1, DW'(1)); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_mask: got %b want 0", irq); end
    nicEn = 0; net_si = 1; net_di = DW'(7); tick();
    net_si = 0;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_on_push: got %b want 1", irq); end
    load(2'd0); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_on_empty: got %b want 0", irq); end
    n_cmp++; if (d_out !== DW'(7)) begin n_err++; $display("FAIL irq_load: got %h want 7", d_out); end
  endtask
`endif

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      nicEn        = $urandom_range(0, 3) != 0;
      nicWrEn      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = rnd_word();
      net_si       = $urandom_range(0, 1);
      net_di       = rnd_word();
      net_ro       = $urandom_range(0, 3) != 0;
      net_polarity = $urandom_range(0, 1);
      #1;
      n_cmp++; if (net_ri !== m_ri()) begin n_err++; $display("FAIL rnd_net_ri[%0d]: got %b want %b", c, net_ri, m_ri()); end
      n_cmp++; if (net_so !== m_so()) begin n_err++; $display("FAIL rnd_net_so[%0d]: got %b want %b", c, net_so, m_so()); end
      if (out_q.size() != 0) begin
        n_cmp++; if (net_do !== out_q[0]) begin n_err++; $display("FAIL rnd_net_do[%0d]: got %h want %h", c, net_do, out_q[0]); end
      end
      tick();
      n_cmp++; if (d_out !== m_dout) begin n_err++; $display("FAIL rnd_d_out[%0d]: got %h want %h", c, d_out, m_dout); end
`ifdef CARDINAL_NIC_IRQ_EN
      n_cmp++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq[%0d]: got %b want %b", c, irq, m_irq); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_in_fill();
    test_in_empty();
    test_out_polarity();
    test_out_full();
    test_reset_mid();
`ifdef CARDINAL_NIC_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
